// File: rtl/imem_loader.sv
// Streams a little-endian byte program into instruction memory and holds the core in reset until done.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word (state CHK).
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LEN_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      xor_q, xor_d;
`endif

    logic             in_ready_q, in_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             core_rst_q, core_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             len_ok;

    assign accept = in_valid && in_ready_q;
    assign len_ok = (len_words != '0) && (len_words <= LEN_W'(DEPTH_WORDS));

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        idx_d   = idx_q;
        len_d   = len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = S_RECV;
                        len_d   = len_words;
                        idx_d   = '0;
                        cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    word_d[{cnt_q, 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = xor_q ^ word_d;
`endif
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + LEN_W'(1);
                if (idx_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    word_d[{cnt_q, 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = (word_d == xor_q) ? S_DONE : S_ERR;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        in_ready_d   = (state_d == S_RECV);
        busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready_d   = in_ready_d || (state_d == S_CHK);
        busy_d       = busy_d || (state_d == S_CHK);
`endif
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        core_rst_d   = (state_d != S_DONE);
        imem_we_d    = (state_d == S_WRITE);
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (state_d == S_WRITE) begin
            imem_addr_d  = 32'(idx_q) << 2;
            imem_wdata_d = word_d;
        end
    end

    // State and output registers; reset wins over any start or byte accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            len_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: inputs driven and outputs sampled on the falling edge.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the checksum variant.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  len_words = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    bit          busy_watch = 1'b0;
    int          busy_drops = 0;

    imem_loader #(.DEPTH_WORDS(64), .LEN_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Log every write-strobe cycle and watch for busy dropping mid-load.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (busy_watch && busy !== 1'b1) busy_drops++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; len_words = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_start(input logic [6:0] len);
        start = 1'b1; len_words = len;
        tick();
        start = 1'b0;
    endtask

    // Present one byte until in_ready allows it, bounded by a cycle budget.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        in_valid = 1'b1; in_data = b;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_vec++;
        if (w >= 20) begin
            n_miss++;
            $display("FAIL send_byte.timeout: in_ready=%b after %0d cycles, want 1", in_ready, w);
        end
        tick();
        in_valid = 1'b0; in_data = 8'hEE;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic gap();
        in_valid = 1'b0; in_data = 8'hA5;
        tick();
    endtask

    // From the last WRITE cycle, step to DONE (sending the checksum word when enabled).
    task automatic finish_load(input logic [31:0] chk);
        tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(chk);
`else
        if (chk === 32'hx) tick();
`endif
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL reset.in_ready got %b want 0", in_ready); end
        n_vec++; if (imem_we !== 1'b0) begin n_miss++; $display("FAIL reset.imem_we got %b want 0", imem_we); end
        n_vec++; if (imem_addr !== 32'h0) begin n_miss++; $display("FAIL reset.imem_addr got %h want 0", imem_addr); end
        n_vec++; if (imem_wdata !== 32'h0) begin n_miss++; $display("FAIL reset.imem_wdata got %h want 0", imem_wdata); end
        n_vec++; if (core_rst !== 1'b1) begin n_miss++; $display("FAIL reset.core_rst got %b want 1", core_rst); end
        n_vec++; if ({busy, done, err} !== 3'b000) begin n_miss++; $display("FAIL reset.status got %b want 000", {busy, done, err}); end
    endtask

    task automatic test_single_word();
        do_reset();
        clear_log();
        send_start(7'd1);
        n_vec++; if ({in_ready, busy, core_rst} !== 3'b111) begin n_miss++; $display("FAIL single.recv got %b want 111", {in_ready, busy, core_rst}); end
        send_word(32'h00500013);
        n_vec++; if (imem_we !== 1'b1) begin n_miss++; $display("FAIL single.we got %b want 1", imem_we); end
        n_vec++; if (imem_addr !== 32'h0) begin n_miss++; $display("FAIL single.addr got %h want 0", imem_addr); end
        n_vec++; if (imem_wdata !== 32'h00500013) begin n_miss++; $display("FAIL single.wdata got %h want 00500013", imem_wdata); end
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL single.ready_in_write got %b want 0", in_ready); end
        finish_load(32'h00500013);
        n_vec++; if ({done, core_rst, busy, err, imem_we} !== 5'b10000) begin n_miss++; $display("FAIL single.done got %b want 10000", {done, core_rst, busy, err, imem_we}); end
        tick();
        n_vec++; if (wr_addr.size() !== 1) begin n_miss++; $display("FAIL single.write_count got %0d want 1", wr_addr.size()); end
    endtask

    task automatic test_gapped_load();
        logic [31:0] words[3];
        logic [31:0] x;
        words[0] = 32'hA1B2C3D4; words[1] = 32'h01020304; words[2] = 32'hDEADBEEF;
        x = words[0] ^ words[1] ^ words[2];
        do_reset();
        clear_log();
        send_start(7'd3);
        busy_drops = 0;
        busy_watch = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) begin
                gap();
                send_byte(words[i][8*j +: 8]);
            end
        busy_watch = 1'b0;
        finish_load(x);
        n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL gapped.done got %b want 1", done); end
        n_vec++; if (busy_drops !== 0) begin n_miss++; $display("FAIL gapped.busy_drops got %0d want 0", busy_drops); end
        n_vec++; if (wr_addr.size() !== 3) begin n_miss++; $display("FAIL gapped.write_count got %0d want 3", wr_addr.size()); end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            n_vec++; if (wr_addr[i] !== 32'(4 * i)) begin n_miss++; $display("FAIL gapped.addr[%0d] got %h want %h", i, wr_addr[i], 32'(4 * i)); end
            n_vec++; if (wr_data[i] !== words[i]) begin n_miss++; $display("FAIL gapped.data[%0d] got %h want %h", i, wr_data[i], words[i]); end
        end
    endtask

    task automatic test_bad_length();
        do_reset();
        clear_log();
        send_start(7'd0);
        n_vec++; if ({err, core_rst, busy, in_ready} !== 4'b1100) begin n_miss++; $display("FAIL badlen.zero got %b want 1100", {err, core_rst, busy, in_ready}); end
        send_start(7'd65);
        n_vec++; if ({err, core_rst, busy} !== 3'b110) begin n_miss++; $display("FAIL badlen.65 got %b want 110", {err, core_rst, busy}); end
        tick();
        n_vec++; if (wr_addr.size() !== 0) begin n_miss++; $display("FAIL badlen.write_count got %0d want 0", wr_addr.size()); end
        send_start(7'd64);
        n_vec++; if ({err, busy, in_ready} !== 3'b011) begin n_miss++; $display("FAIL badlen.max_from_err got %b want 011", {err, busy, in_ready}); end
        do_reset();
    endtask

    task automatic test_abort();
        do_reset();
        clear_log();
        send_start(7'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1; start = 1'b1; len_words = 7'd1; in_valid = 1'b1; in_data = 8'h03;
        tick();
        n_vec++; if ({busy, in_ready, imem_we, done, err} !== 5'b00000) begin n_miss++; $display("FAIL abort.idle got %b want 00000", {busy, in_ready, imem_we, done, err}); end
        n_vec++; if (core_rst !== 1'b1) begin n_miss++; $display("FAIL abort.core_rst got %b want 1", core_rst); end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (6) tick();
        n_vec++; if (wr_addr.size() !== 1) begin n_miss++; $display("FAIL abort.write_count got %0d want 1", wr_addr.size()); end
        if (wr_addr.size() >= 1) begin
            n_vec++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hCAFEF00D) begin n_miss++; $display("FAIL abort.write0 got %h/%h want 0/cafef00d", wr_addr[0], wr_data[0]); end
        end
    endtask

    task automatic test_restart();
        do_reset();
        send_start(7'd1);
        send_word(32'h12345678);
        finish_load(32'h12345678);
        n_vec++; if ({done, core_rst} !== 2'b10) begin n_miss++; $display("FAIL restart.first_done got %b want 10", {done, core_rst}); end
        clear_log();
        send_start(7'd1);
        n_vec++; if ({core_rst, done, in_ready} !== 3'b101) begin n_miss++; $display("FAIL restart.reassert got %b want 101", {core_rst, done, in_ready}); end
        send_word(32'h00000073);
        n_vec++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h0, 32'h00000073}) begin n_miss++; $display("FAIL restart.write got we=%b addr=%h data=%h want 1/0/00000073", imem_we, imem_addr, imem_wdata); end
        finish_load(32'h00000073);
        n_vec++; if ({done, core_rst} !== 2'b10) begin n_miss++; $display("FAIL restart.second_done got %b want 10", {done, core_rst}); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_start(7'd2);
        send_word(32'h11111111);
        send_word(32'h22222222);
        tick();
        n_vec++; if ({in_ready, busy, imem_we} !== 3'b110) begin n_miss++; $display("FAIL chk.state got %b want 110", {in_ready, busy, imem_we}); end
        send_word(32'h33333333);
        n_vec++; if ({done, err, core_rst} !== 3'b100) begin n_miss++; $display("FAIL chk.good got %b want 100", {done, err, core_rst}); end
        send_start(7'd2);
        send_word(32'h11111111);
        send_word(32'h22222222);
        tick();
        send_word(32'h33333334);
        n_vec++; if ({done, err, core_rst} !== 3'b011) begin n_miss++; $display("FAIL chk.bad got %b want 011", {done, err, core_rst}); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_gapped_load();
        test_bad_length();
        test_abort();
        test_restart();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter LEN_W, default 7, meaning width of len_words; must satisfy 2^LEN_W > DEPTH_WORDS.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port len_words  input  LEN_W  number of words to load, sampled when start is accepted.
REQ-007 SHALL have port in_valid  input  1  the source has a byte on in_data.
REQ-008 SHALL have port in_data  input  8  program byte stream, little-endian within each word.
REQ-009 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  32  word-aligned byte address for the write.
REQ-012 SHALL have port imem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port core_rst  output  1  reset driven to the processor core's rst input.
REQ-014 SHALL have ports busy, done and err  output  1 each  load in progress, load complete, load aborted.

Function
REQ-015 SHALL implement the states IDLE, RECV, WRITE, DONE and ERR.
REQ-016 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high only in RECV.
REQ-017 Byte k (k = 0..3) of each word SHALL land in bits [8k+7:8k]; a 2-bit byte counter SHALL wrap from 3 to 0.
REQ-018 Acceptance of byte 3 SHALL move the FSM to WRITE; WRITE SHALL last exactly one cycle with imem_we=1, imem_wdata = the assembled word, and imem_addr = 4*word_index.
REQ-019 After WRITE, word_index SHALL increment; when it equals the latched length, the FSM SHALL go to DONE, otherwise back to RECV.
REQ-020 The minimum rate SHALL be 5 cycles per word (4 accept cycles plus 1 WRITE); in_valid gaps SHALL stall without data loss.
REQ-021 start in IDLE or DONE with 1 <= len_words <= DEPTH_WORDS SHALL latch the length, clear word_index and the byte counter, and enter RECV on the next cycle.
REQ-022 start with len_words = 0 or len_words > DEPTH_WORDS SHALL enter ERR instead.
REQ-023 start SHALL be ignored in RECV and WRITE; start in ERR SHALL be handled as in IDLE.
REQ-024 core_rst SHALL be 0 only in DONE and 1 in every other state, so that a restart from DONE reasserts it on the next cycle.
REQ-025 busy SHALL be 1 in RECV and WRITE; done SHALL be 1 in DONE; err SHALL be 1 in ERR; imem_we SHALL be 0 outside WRITE.
REQ-026 in_data SHALL be ignored whenever in_ready is 0.

Reset
REQ-027 rst=1 on a clock edge SHALL force IDLE, word_index=0, byte counter=0, imem_addr=0, imem_wdata=0, imem_we=0, in_ready=0, busy=0, done=0, err=0 and core_rst=1.
REQ-028 rst SHALL abort a load in progress; words already written SHALL NOT be rewritten, and no partial word SHALL be written.
REQ-029 rst SHALL take priority over start and over a byte accept in the same cycle.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN SHALL select checksum handling.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, the loader SHALL receive 4 more bytes (state CHK, in_ready=1, little-endian) as a checksum word. A match with the XOR of all written words SHALL go to DONE; a mismatch SHALL go to ERR with core_rst held at 1.
REQ-032 With the macro undefined: the loader SHALL have no CHK state and SHALL go from the last WRITE directly to DONE.

Verification
REQ-033 rst, then start with len_words=1 and bytes 13,00,50,00 -> exactly one cycle with imem_we=1, imem_addr=0, imem_wdata=0x00500013; then done=1, core_rst=0.
REQ-034 start with len_words=3, 12 bytes with in_valid toggled every other cycle -> writes to addresses 0x0, 0x4, 0x8 in order with correct words; busy=1 throughout.
REQ-035 start with len_words=0 and, separately, len_words=65 -> err=1, core_rst=1, no imem_we pulse.
REQ-036 rst asserted after 2 bytes of word 1 with len_words=2 -> IDLE next cycle, core_rst=1, only address 0x0 ever written.
REQ-037 From DONE, start with len_words=1 -> core_rst=1 the next cycle and the write goes to address 0x0.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined: words 0x11111111 and 0x22222222 with checksum 0x33333333 -> done=1; with checksum 0x33333334 -> err=1, core_rst=1.
